row_requantize_serializer: RTL and testbench

Drains one 8-wide row of signed 2W-bit dot-product results per capture. Each element is rounded, shifted and saturated back to W bits, with optional ReLU, and the row is streamed out one element per beat under valid/ready. The block sits directly downstream of a row-by-matrix multiply stage, which has no backpressure. It converts that stage's parallel accumulator outputs into the W-bit sample stream consumed by the next layer or the DAC path.

---
 rtl/row_requantize_serializer.sv | 138 +++++++++++++
 tb/tb_row_requantize_serializer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_requantize_serializer.sv
// Captures one 8-wide row of 2W-bit accumulators, requantizes every element in
// parallel (round half up, arithmetic shift, saturate, optional ReLU) and streams it out.
//
// state  | meaning
// S_IDLE | no row held, out_v=0, always ready to capture
// S_SEND | row buffered, emitting element idx_q under valid/ready

module row_requantize_serializer #(
  parameter int W     = 16,
  parameter int SHIFT = 12,
  parameter bit RELU  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*W-1:0]  in_d0,
  input  logic [2*W-1:0]  in_d1,
  input  logic [2*W-1:0]  in_d2,
  input  logic [2*W-1:0]  in_d3,
  input  logic [2*W-1:0]  in_d4,
  input  logic [2*W-1:0]  in_d5,
  input  logic [2*W-1:0]  in_d6,
  input  logic [2*W-1:0]  in_d7,
  input  logic            in_v,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic [2:0]      out_idx,
  output logic            out_last,
  output logic            out_sat,
  output logic            out_v,
  input  logic            out_ready,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Rounding constant is 2^(SHIFT-1), or 0 when nothing is dropped.
  localparam logic [2*W:0] RND = ((2*W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic [0:0]     state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   data_q [8];
  logic [7:0]     sat_q;

  logic [2*W-1:0] row [8];
  logic [W-1:0]   q_data [8];
  logic [7:0]     q_sat;
  logic           capture, drop, beat;

  function automatic logic [W:0] requant(input logic [2*W-1:0] x);
    logic signed [2*W:0] t;
    logic signed [2*W:0] r;
    logic [W-1:0]        res;
    logic                sat;
    t   = $signed({x[2*W-1], x}) + $signed(RND);
    r   = t >>> SHIFT;
    sat = 1'b1;
    if (r > MAXV) begin
      res = MAXV[W-1:0];
    end else if (r < MINV) begin
      res = MINV[W-1:0];
    end else begin
      res = r[W-1:0];
      sat = 1'b0;
    end
    if (RELU && res[W-1]) res = '0;
    return {sat, res};
  endfunction

  assign row[0] = in_d0;
  assign row[1] = in_d1;
  assign row[2] = in_d2;
  assign row[3] = in_d3;
  assign row[4] = in_d4;
  assign row[5] = in_d5;
  assign row[6] = in_d6;
  assign row[7] = in_d7;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      {q_sat[i], q_data[i]} = requant(row[i]);
    end
  end

  assign out_v    = (state_q == S_SEND);
  assign in_ready = (state_q == S_IDLE) || (out_v && idx_q == 3'd7 && out_ready);
  assign capture  = in_v && in_ready;
  assign drop     = in_v && !in_ready;
  assign beat     = out_v && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (capture) begin
      state_d = S_SEND;
      idx_d   = 3'd0;
    end else if (beat) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) state_d = S_IDLE;
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      ovf_q   <= 1'b0;
      sat_q   <= '0;
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      if (capture) begin
        sat_q <= q_sat;
        for (int i = 0; i < 8; i++) data_q[i] <= q_data[i];
      end
    end
  end

  assign out_data = data_q[idx_q];
  assign out_sat  = sat_q[idx_q];
  assign out_idx  = idx_q;
  assign out_last = out_v && (idx_q == 3'd7);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_row_requantize_serializer.sv
// Drives two instances (RELU=0 and RELU=1) with shared stimulus and checks the
// streamed beats against an arithmetic reference of the requantization rule.

module tb_row_requantize_serializer;
  localparam int W = 16;
  localparam int SHIFT = 12;

  typedef logic [31:0] row_t [8];
  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic [2:0]  idx;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d [8];
  logic        in_v = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;

  logic        r0_ready, r0_last, r0_sat, r0_v, r0_ovf;
  logic [15:0] r0_data;
  logic [2:0]  r0_idx;
  logic        r1_ready, r1_last, r1_sat, r1_v, r1_ovf;
  logic [15:0] r1_data;
  logic [2:0]  r1_idx;

  int n_cmp = 0, n_bad = 0, cyc = 0, stall_bad = 0;
  beat_t q0[$], q1[$];
  logic        prev_stall = 1'b0, p_sat = 1'b0;
  logic [15:0] p_data = '0;
  logic [2:0]  p_idx = '0;

  row_requantize_serializer #(.W(W), .SHIFT(SHIFT), .RELU(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .in_d0(d[0]), .in_d1(d[1]), .in_d2(d[2]), .in_d3(d[3]),
    .in_d4(d[4]), .in_d5(d[5]), .in_d6(d[6]), .in_d7(d[7]),
    .in_v(in_v), .in_ready(r0_ready), .out_data(r0_data), .out_idx(r0_idx),
    .out_last(r0_last), .out_sat(r0_sat), .out_v(r0_v), .out_ready(out_ready),
    .overflow(r0_ovf), .ovf_clr(ovf_clr));

  row_requantize_serializer #(.W(W), .SHIFT(SHIFT), .RELU(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .in_d0(d[0]), .in_d1(d[1]), .in_d2(d[2]), .in_d3(d[3]),
    .in_d4(d[4]), .in_d5(d[5]), .in_d6(d[6]), .in_d7(d[7]),
    .in_v(in_v), .in_ready(r1_ready), .out_data(r1_data), .out_idx(r1_idx),
    .out_last(r1_last), .out_sat(r1_sat), .out_v(r1_v), .out_ready(out_ready),
    .overflow(r1_ovf), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor on the falling edge, plus stall-stability tracking on u0.
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_v && out_ready) q0.push_back('{r0_data, r0_sat, r0_idx, r0_last, cyc});
      if (r1_v && out_ready) q1.push_back('{r1_data, r1_sat, r1_idx, r1_last, cyc});
      if (prev_stall && (!r0_v || r0_data !== p_data || r0_idx !== p_idx || r0_sat !== p_sat))
        stall_bad++;
      prev_stall = r0_v && !out_ready;
      p_data = r0_data;
      p_idx  = r0_idx;
      p_sat  = r0_sat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Reference: exact integer arithmetic on the mathematical value of x.
  function automatic logic [16:0] model(input logic [31:0] x, input bit relu);
    longint t, r;
    logic [15:0] v;
    logic s;
    t = longint'($signed(x)) + (longint'(1) << (SHIFT - 1));
    r = t >>> SHIFT;
    s = 1'b1;
    if (r > 32767) v = 16'h7FFF;
    else if (r < -32768) v = 16'h8000;
    else begin
      v = r[15:0];
      s = 1'b0;
    end
    if (relu && v[15]) v = '0;
    return {s, v};
  endfunction

  function automatic logic [31:0] rand_elem();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
      1: v = $urandom;
      2: v = {$urandom_range(0, 40000), 12'h800} - 32'($urandom_range(0, 1)) - 32'h0400_0000;
      default: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
    return v;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = rand_elem();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a row for exactly one edge; returns just after that edge.
  task automatic apply_row(input row_t r);
    for (int i = 0; i < 8; i++) d[i] = r[i];
    in_v = 1'b1;
    step();
    in_v = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int k = 0; k < budget && q0.size() < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({r0_v, r0_data, r0_idx, r0_last, r0_sat, r0_ovf} !== 23'd0 ||
        {r1_v, r1_data, r1_idx, r1_last, r1_sat, r1_ovf} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got u0=%h u1=%h want 0",
               {r0_v, r0_data, r0_idx, r0_last, r0_sat, r0_ovf},
               {r1_v, r1_data, r1_idx, r1_last, r1_sat, r1_ovf});
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b1 || r0_v !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b%b out_v=%b want 11 out_v=0", r0_ready, r1_ready, r0_v);
    end
  endtask

  task automatic test_round_shift();
    row_t r;
    logic [15:0] e0 [8];
    logic [15:0] e1 [8];
    int cap;
    e0 = '{16'h0002, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    e1 = '{16'h0002, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    r  = '{32'h0000_1800, 32'hFFFF_E800, 32'h0000_1000, 0, 0, 0, 0, 0};
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    apply_row(r);
    cap = cyc;
    wait_beats(8, 20);
    step(); step();
    n_cmp++;
    if (q0.size() != 8 || q1.size() != 8 || r0_v !== 1'b0) begin
      n_bad++;
      $display("FAIL round_beat_count: got %0d/%0d out_v=%b want 8/8 out_v=0", q0.size(), q1.size(), r0_v);
    end
    for (int i = 0; i < 8 && i < q0.size() && i < q1.size(); i++) begin
      n_cmp++;
      if (q0[i].data !== e0[i] || q0[i].sat !== 1'b0 || q0[i].idx !== 3'(i) ||
          q0[i].last !== (i == 7) || q0[i].cyc != cap + i || q1[i].data !== e1[i]) begin
        n_bad++;
        $display("FAIL round_beat%0d: got d=%h/%h idx=%0d last=%b cyc=%0d want d=%h/%h idx=%0d last=%b cyc=%0d",
                 i, q0[i].data, q1[i].data, q0[i].idx, q0[i].last, q0[i].cyc,
                 e0[i], e1[i], i, (i == 7), cap + i);
      end
    end
  endtask

  task automatic test_saturation_relu();
    row_t ra, rb;
    logic [16:0] e0 [16];
    logic [16:0] e1 [16];
    ra = '{32'h1000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0};
    rb = '{32'hFFFF_E800, 32'h8000_0000, 32'h0000_3000, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      e0[i] = '0;
      e1[i] = '0;
    end
    e0[0] = {1'b1, 16'h7FFF}; e0[1] = {1'b1, 16'h8000};
    e1[0] = {1'b1, 16'h7FFF}; e1[1] = {1'b1, 16'h0000};
    e0[8] = {1'b0, 16'hFFFF}; e0[9] = {1'b1, 16'h8000}; e0[10] = {1'b0, 16'h0003};
    e1[8] = {1'b0, 16'h0000}; e1[9] = {1'b1, 16'h0000}; e1[10] = {1'b0, 16'h0003};
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    apply_row(ra);
    wait_beats(8, 20);
    apply_row(rb);
    wait_beats(16, 20);
    n_cmp++;
    if (q0.size() != 16 || q1.size() != 16) begin
      n_bad++;
      $display("FAIL satrelu_count: got %0d/%0d want 16/16", q0.size(), q1.size());
    end
    for (int i = 0; i < 16 && i < q0.size() && i < q1.size(); i++) begin
      n_cmp++;
      if ({q0[i].sat, q0[i].data} !== e0[i] || {q1[i].sat, q1[i].data} !== e1[i]) begin
        n_bad++;
        $display("FAIL satrelu_beat%0d: got relu0=%h relu1=%h want relu0=%h relu1=%h",
                 i, {q0[i].sat, q0[i].data}, {q1[i].sat, q1[i].data}, e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_random_rows();
    row_t rows[$];
    int j;
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      rows.push_back(rand_row());
      apply_row(rows[n]);
      wait_beats(8 * (n + 1), 20);
      repeat ($urandom_range(0, 2)) step();
    end
    n_cmp++;
    if (q0.size() != 48 || q1.size() != 48) begin
      n_bad++;
      $display("FAIL random_count: got %0d/%0d want 48/48", q0.size(), q1.size());
    end
    for (j = 0; j < 48 && j < q0.size() && j < q1.size(); j++) begin
      n_cmp++;
      if ({q0[j].sat, q0[j].data} !== model(rows[j / 8][j % 8], 1'b0) ||
          {q1[j].sat, q1[j].data} !== model(rows[j / 8][j % 8], 1'b1) ||
          q0[j].idx !== 3'(j % 8) || q0[j].last !== (j % 8 == 7)) begin
        n_bad++;
        $display("FAIL random_beat%0d: x=%h got %h/%h idx=%0d want %h/%h idx=%0d",
                 j, rows[j / 8][j % 8], {q0[j].sat, q0[j].data}, {q1[j].sat, q1[j].data},
                 q0[j].idx, model(rows[j / 8][j % 8], 1'b0), model(rows[j / 8][j % 8], 1'b1), j % 8);
      end
    end
  endtask

  task automatic test_backpressure();
    row_t r;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    r = rand_row();
    q0.delete(); q1.delete();
    stall_bad = 0;
    out_ready = 1'b1;
    apply_row(r);
    for (int k = 0; k < 80 && q0.size() < 8; k++) begin
      out_ready = pat[k % 6];
      step();
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (stall_bad != 0) begin
      n_bad++;
      $display("FAIL bp_stall_stable: got %0d changes during stalls want 0", stall_bad);
    end
    n_cmp++;
    if (q0.size() != 8 || r0_v !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d beats out_v=%b want 8 out_v=0", q0.size(), r0_v);
    end
    for (int i = 0; i < 8 && i < q0.size() && i < q1.size(); i++) begin
      n_cmp++;
      if ({q0[i].sat, q0[i].data} !== model(r[i], 1'b0) || q0[i].idx !== 3'(i) ||
          {q1[i].sat, q1[i].data} !== model(r[i], 1'b1)) begin
        n_bad++;
        $display("FAIL bp_beat%0d: got %h idx=%0d want %h idx=%0d",
                 i, {q0[i].sat, q0[i].data}, q0[i].idx, model(r[i], 1'b0), i);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t ra, rb, rc;
    int cap;
    ra = rand_row(); rb = rand_row(); rc = rand_row();
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    apply_row(ra);
    cap = cyc;
    repeat (7) step();
    n_cmp++;
    if (r0_idx !== 3'd7 || r0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_at_last: got idx=%0d ready=%b want idx=7 ready=1", r0_idx, r0_ready);
    end
    apply_row(rb);
    repeat (3) step();
    n_cmp++;
    if (r0_idx !== 3'd3 || r0_ready !== 1'b0 || r0_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_mid_row: got idx=%0d ready=%b ovf=%b want idx=3 ready=0 ovf=0",
               r0_idx, r0_ready, r0_ovf);
    end
    apply_row(rc);
    n_cmp++;
    if (r0_ovf !== 1'b1 || r1_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_overflow: got %b%b want 11", r0_ovf, r1_ovf);
    end
    wait_beats(16, 30);
    n_cmp++;
    if (q0.size() != 16) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 16", q0.size());
    end
    for (int j = 0; j < 16 && j < q0.size(); j++) begin
      n_cmp++;
      if ({q0[j].sat, q0[j].data} !== model((j < 8) ? ra[j % 8] : rb[j % 8], 1'b0) ||
          q0[j].idx !== 3'(j % 8) || q0[j].cyc != cap + j) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got %h idx=%0d cyc=%0d want %h idx=%0d cyc=%0d",
                 j, {q0[j].sat, q0[j].data}, q0[j].idx, q0[j].cyc,
                 model((j < 8) ? ra[j % 8] : rb[j % 8], 1'b0), j % 8, cap + j);
      end
    end
    apply_row(ra);
    for (int i = 0; i < 8; i++) d[i] = rc[i];
    in_v = 1'b1;
    ovf_clr = 1'b1;
    step();
    in_v = 1'b0;
    n_cmp++;
    if (r0_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_clr_vs_drop: got %b want 1", r0_ovf);
    end
    step();
    ovf_clr = 1'b0;
    n_cmp++;
    if (r0_ovf !== 1'b0 || r1_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clr_alone: got %b%b want 00", r0_ovf, r1_ovf);
    end
    for (int k = 0; k < 20 && r0_v; k++) step();
  endtask

  task automatic test_async_reset();
    row_t re, rf;
    re = rand_row(); rf = rand_row();
    re[4] = 32'h0001_2345;
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    apply_row(re);
    repeat (4) step();
    n_cmp++;
    if (r0_idx !== 3'd4 || r0_v !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got idx=%0d v=%b want idx=4 v=1", r0_idx, r0_v);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({r0_v, r0_idx, r0_data, r1_v, r1_idx, r1_data} !== 40'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: got v=%b idx=%0d d=%h want 0 0 0", r0_v, r0_idx, r0_data);
    end
    step();
    step();
    rst = 1'b0;
    q0.delete(); q1.delete();
    repeat (3) step();
    n_cmp++;
    if (r0_ready !== 1'b1 || q0.size() != 0 || r0_v !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_after: got ready=%b beats=%0d v=%b want 1 0 0", r0_ready, q0.size(), r0_v);
    end
    apply_row(rf);
    wait_beats(8, 20);
    n_cmp++;
    if (q0.size() != 8) begin
      n_bad++;
      $display("FAIL arst_row_count: got %0d want 8", q0.size());
    end
    for (int i = 0; i < 8 && i < q0.size() && i < q1.size(); i++) begin
      n_cmp++;
      if ({q0[i].sat, q0[i].data} !== model(rf[i], 1'b0) || q0[i].idx !== 3'(i) ||
          {q1[i].sat, q1[i].data} !== model(rf[i], 1'b1)) begin
        n_bad++;
        $display("FAIL arst_beat%0d: got %h idx=%0d want %h idx=%0d",
                 i, {q0[i].sat, q0[i].data}, q0[i].idx, model(rf[i], 1'b0), i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = '0;
    test_reset();
    test_round_shift();
    test_saturation_relu();
    test_random_rows();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
